parking_count_ctrl: RTL and testbench

//  Sequences one shared 1-bit add/sub cell (full_adder_onebit) bit-serially, LSB first, to keep the lot occupancy count.

---
 rtl/park_pkg.sv | 13 +
 rtl/full_adder_onebit.sv | 17 +
 rtl/parking_count_ctrl.sv | 153 +++++++++++++++
 tb/tb_parking_count_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/park_pkg.sv
// Shared types and default sizing for the parking occupancy counter.
package park_pkg;

  localparam int unsigned DEF_W        = 8;
  localparam int unsigned DEF_CAPACITY = 200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_onebit.sv
// One-bit add/sub cell: sel=1 inverts b so a carry-in of 1 yields a - b.
module full_adder_onebit (
  input  logic a,
  input  logic b,
  input  logic sel,
  input  logic cin,
  output logic sum_c,
  output logic cout_c
);

  logic bx;

  assign bx     = b ^ sel;
  assign sum_c  = a ^ bx ^ cin;
  assign cout_c = (a & bx) | (cin & (a ^ bx));

endmodule

// File: rtl/parking_count_ctrl.sv
// Lot occupancy counter updated bit-serially through one shared add/sub cell.
// Optional macro PARK_FREE_CNT_EN adds the registered free_cnt output.
module parking_count_ctrl
  import park_pkg::*;
#(
  parameter int unsigned W        = DEF_W,
  parameter int unsigned CAPACITY = DEF_CAPACITY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         entry_req,
  input  logic         exit_req,
  output logic         entry_ack,
  output logic         entry_rej,
  output logic         exit_ack,
  output logic         exit_rej,
  output logic         busy,
  output logic [W-1:0] count,
`ifdef PARK_FREE_CNT_EN
  output logic [W-1:0] free_cnt,
`endif
  output logic         full,
  output logic         empty
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  state_t        state;
  logic          entry_pend;
  logic          exit_pend;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  r_sh;
  logic          sel;
  logic          carry;
  logic [CW-1:0] bit_cnt;

  logic          sum_c;
  logic          cout_c;
  logic          last_c;
  logic          entry_clr_c;
  logic          exit_clr_c;
  logic [W-1:0]  res_c;

  full_adder_onebit u_fa (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .sel    (sel),
    .cin    (carry),
    .sum_c  (sum_c),
    .cout_c (cout_c)
  );

  assign last_c = (state == SHIFT) && (bit_cnt == CW'(W - 1));
  assign res_c  = {sum_c, r_sh[W-1:1]};

  // Pending flags are retired by netting, rejection, or the last serial bit
  always_comb begin
    entry_clr_c = 1'b0;
    exit_clr_c  = 1'b0;
    if (state == IDLE) begin
      entry_clr_c = entry_pend && (exit_pend || full);
      exit_clr_c  = exit_pend && (entry_pend || empty);
    end else if (last_c) begin
      entry_clr_c = !sel;
      exit_clr_c  = sel;
    end
  end

  // At most one outstanding request per side; extra pulses are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_pend <= 1'b0;
      exit_pend  <= 1'b0;
    end else begin
      entry_pend <= (entry_pend && !entry_clr_c) || (entry_req && !entry_pend);
      exit_pend  <= (exit_pend && !exit_clr_c) || (exit_req && !exit_pend);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      busy      <= 1'b0;
      entry_ack <= 1'b0;
      entry_rej <= 1'b0;
      exit_ack  <= 1'b0;
      exit_rej  <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      sel       <= 1'b0;
      carry     <= 1'b0;
      bit_cnt   <= '0;
`ifdef PARK_FREE_CNT_EN
      free_cnt  <= W'(CAPACITY);
`endif
    end else begin
      entry_ack <= 1'b0;
      entry_rej <= 1'b0;
      exit_ack  <= 1'b0;
      exit_rej  <= 1'b0;
      case (state)
        IDLE: begin
          if (entry_pend && exit_pend) begin
            entry_ack <= 1'b1;
            exit_ack  <= 1'b1;
          end else if (entry_pend && full) begin
            entry_rej <= 1'b1;
          end else if (exit_pend && empty) begin
            exit_rej <= 1'b1;
          end else if (entry_pend || exit_pend) begin
            a_sh    <= count;
            b_sh    <= W'(1);
            sel     <= exit_pend;
            carry   <= exit_pend;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // LSB first: sums fill r_sh from the top, final carry is dropped
          r_sh    <= res_c;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry   <= cout_c;
          bit_cnt <= bit_cnt + CW'(1);
          if (last_c) begin
            count <= res_c;
`ifdef PARK_FREE_CNT_EN
            free_cnt <= W'(CAPACITY) - res_c;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          entry_ack <= !sel;
          exit_ack  <= sel;
          busy      <= 1'b0;
          full      <= (count == W'(CAPACITY));
          empty     <= (count == '0);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_count_ctrl.sv
// Self-checking bench for parking_count_ctrl: directed scenarios plus randomized traffic vs a timing model.
module tb_parking_count_ctrl;

  localparam int W   = 8;
  localparam int CAP = 200;

  logic         clk;
  logic         rst;
  logic         entry_req;
  logic         exit_req;
  logic         entry_ack;
  logic         entry_rej;
  logic         exit_ack;
  logic         exit_rej;
  logic         busy;
  logic [W-1:0] count;
`ifdef PARK_FREE_CNT_EN
  logic [W-1:0] free_cnt;
`endif
  logic         full;
  logic         empty;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (plain arithmetic on counts and edge indices)
  int m_count;
  bit m_pe, m_px, m_inflight, m_dir, m_full, m_empty;
  int m_commit_at, m_done_at;
  bit x_eack, x_erej, x_xack, x_xrej;

  parking_count_ctrl #(.W(W), .CAPACITY(CAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .entry_req (entry_req),
    .exit_req  (exit_req),
    .entry_ack (entry_ack),
    .entry_rej (entry_rej),
    .exit_ack  (exit_ack),
    .exit_rej  (exit_rej),
    .busy      (busy),
    .count     (count),
`ifdef PARK_FREE_CNT_EN
    .free_cnt  (free_cnt),
`endif
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    entry_req = 1'b0;
    exit_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input bit e, input bit x);
    entry_req = e;
    exit_req  = x;
    @(negedge clk);
    entry_req = 1'b0;
    exit_req  = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      pulse(1'b1, 1'b0);
      repeat (11) @(negedge clk);
    end
  endtask

  // One posedge of the model: serial update commits W edges after load, acks one edge later
  task automatic model_step(input int n, input bit er, input bit xr);
    bit pe, px, ce, cx;
    pe = m_pe; px = m_px; ce = 1'b0; cx = 1'b0;
    x_eack = 1'b0; x_erej = 1'b0; x_xack = 1'b0; x_xrej = 1'b0;
    if (m_inflight) begin
      if (n == m_commit_at) begin
        m_count = m_dir ? m_count - 1 : m_count + 1;
        if (m_dir) cx = 1'b1; else ce = 1'b1;
      end else if (n == m_done_at) begin
        if (m_dir) x_xack = 1'b1; else x_eack = 1'b1;
        m_full = (m_count == CAP);
        m_empty = (m_count == 0);
        m_inflight = 1'b0;
      end
    end else begin
      if (pe && px) begin
        x_eack = 1'b1; x_xack = 1'b1; ce = 1'b1; cx = 1'b1;
      end else if (pe && m_full) begin
        x_erej = 1'b1; ce = 1'b1;
      end else if (px && m_empty) begin
        x_xrej = 1'b1; cx = 1'b1;
      end else if (pe || px) begin
        m_inflight = 1'b1;
        m_dir = px;
        m_commit_at = n + W;
        m_done_at = n + W + 1;
      end
    end
    m_pe = (pe && !ce) || (er && !pe);
    m_px = (px && !cx) || (xr && !px);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    entry_req = 1'b0;
    exit_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (count !== 8'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_checks++;
    if ({full, empty, busy} !== 3'b010) $display("FAIL reset_flags got=%b exp=010", {full, empty, busy});
    else n_pass++;
    n_checks++;
    if ({entry_ack, entry_rej, exit_ack, exit_rej} !== 4'b0000)
      $display("FAIL reset_pulses got=%b exp=0000", {entry_ack, entry_rej, exit_ack, exit_rej});
    else n_pass++;
`ifdef PARK_FREE_CNT_EN
    n_checks++;
    if (free_cnt !== 8'(CAP)) $display("FAIL reset_free got=%0d exp=%0d", free_cnt, CAP); else n_pass++;
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_entry_serial();
    int lat;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      lat = -1;
      pulse(1'b1, 1'b0);
      for (int c = 2; c <= 12; c++) begin
        @(negedge clk);
        if (entry_ack === 1'b1 && lat < 0) lat = c;
      end
      n_checks++;
      if (lat !== 11) $display("FAIL entry_latency[%0d] got=%0d exp=11", i, lat); else n_pass++;
    end
    n_checks++;
    if (count !== 8'd5) $display("FAIL entry_count got=%0d exp=5", count); else n_pass++;
    n_checks++;
    if (empty !== 1'b0) $display("FAIL entry_empty got=%b exp=0", empty); else n_pass++;
  endtask

  task automatic test_empty_reject();
    do_reset();
    pulse(1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({exit_rej, exit_ack} !== 2'b10) $display("FAIL empty_rej got=%b exp=10", {exit_rej, exit_ack});
    else n_pass++;
    n_checks++;
    if ({count, empty} !== {8'd0, 1'b1}) $display("FAIL empty_state got=%0d/%b exp=0/1", count, empty);
    else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_full_reject();
    bit saw_ack;
    do_reset();
    fill(CAP);
    n_checks++;
    if ({count, full} !== {8'(CAP), 1'b1}) $display("FAIL fill_state got=%0d/%b exp=%0d/1", count, full, CAP);
    else n_pass++;
    pulse(1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({entry_rej, entry_ack} !== 2'b10) $display("FAIL full_rej got=%b exp=10", {entry_rej, entry_ack});
    else n_pass++;
    saw_ack = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (entry_ack === 1'b1) saw_ack = 1'b1;
    end
    n_checks++;
    if ({saw_ack, count, full} !== {1'b0, 8'(CAP), 1'b1})
      $display("FAIL full_after got=ack%b/%0d/%b exp=ack0/%0d/1", saw_ack, count, full, CAP);
    else n_pass++;
  endtask

  task automatic test_net_at_full();
    bit saw_busy;
    saw_busy = 1'b0;
    pulse(1'b1, 1'b1);
    if (busy === 1'b1) saw_busy = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({entry_ack, exit_ack} !== 2'b11) $display("FAIL net_acks got=%b exp=11", {entry_ack, exit_ack});
    else n_pass++;
    repeat (10) begin
      @(negedge clk);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    n_checks++;
    if ({saw_busy, count} !== {1'b0, 8'(CAP)})
      $display("FAIL net_state got=busy%b/%0d exp=busy0/%0d", saw_busy, count, CAP);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t_x, t_e, c_x;
    do_reset();
    fill(7);
    t_x = -1; t_e = -1; c_x = -1;
    pulse(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b0);
    for (int c = 5; c <= 26; c++) begin
      @(negedge clk);
      if (exit_ack === 1'b1 && t_x < 0) begin t_x = c; c_x = int'(count); end
      if (entry_ack === 1'b1 && t_e < 0) t_e = c;
    end
    n_checks++;
    if ({t_x, c_x} !== {32'd11, 32'd6}) $display("FAIL b2b_exit got=t%0d/c%0d exp=t11/c6", t_x, c_x);
    else n_pass++;
    n_checks++;
    if (t_e !== 21) $display("FAIL b2b_entry_time got=%0d exp=21", t_e); else n_pass++;
    n_checks++;
    if (count !== 8'd7) $display("FAIL b2b_count got=%0d exp=7", count); else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    bit saw_ack;
    do_reset();
    fill(100);
    n_checks++;
    if (count !== 8'd100) $display("FAIL mid_pre_count got=%0d exp=100", count); else n_pass++;
    pulse(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({count, busy, empty} !== {8'd0, 1'b0, 1'b1})
      $display("FAIL mid_reset got=%0d/busy%b/empty%b exp=0/busy0/empty1", count, busy, empty);
    else n_pass++;
`ifdef PARK_FREE_CNT_EN
    n_checks++;
    if (free_cnt !== 8'(CAP)) $display("FAIL mid_free got=%0d exp=%0d", free_cnt, CAP); else n_pass++;
`endif
    rst = 1'b0;
    saw_ack = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (entry_ack === 1'b1 || busy === 1'b1) saw_ack = 1'b1;
    end
    n_checks++;
    if ({saw_ack, count} !== {1'b0, 8'd0}) $display("FAIL mid_after got=act%b/%0d exp=act0/0", saw_ack, count);
    else n_pass++;
  endtask

  task automatic test_random(input int init, input int cycles, input int pe_pct, input int px_pct);
    bit er, xr;
    m_count = init;
    m_full = (init == CAP);
    m_empty = (init == 0);
    m_pe = 1'b0; m_px = 1'b0; m_inflight = 1'b0; m_dir = 1'b0;
    m_commit_at = -1; m_done_at = -1;
    for (int n = 0; n < cycles + 30; n++) begin
      er = (n < cycles) && ($urandom_range(99) < pe_pct);
      xr = (n < cycles) && ($urandom_range(99) < px_pct);
      entry_req = er;
      exit_req = xr;
      model_step(n, er, xr);
      @(negedge clk);
      n_checks++;
      if ({entry_ack, entry_rej, exit_ack, exit_rej} !== {x_eack, x_erej, x_xack, x_xrej})
        $display("FAIL rnd_pulses n=%0d got=%b exp=%b", n, {entry_ack, entry_rej, exit_ack, exit_rej},
                 {x_eack, x_erej, x_xack, x_xrej});
      else n_pass++;
      n_checks++;
      if (busy !== m_inflight) $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, m_inflight);
      else n_pass++;
      n_checks++;
      if (count !== 8'(m_count)) $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, m_count);
      else n_pass++;
      n_checks++;
      if ({full, empty} !== {m_full, m_empty})
        $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, {full, empty}, {m_full, m_empty});
      else n_pass++;
    end
    entry_req = 1'b0;
    exit_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    entry_req = 1'b0;
    exit_req = 1'b0;
    @(negedge clk);
    test_reset();
    test_entry_serial();
    test_empty_reject();
    test_full_reject();
    test_net_at_full();
    test_random(CAP, 1500, 20, 12);
    test_back_to_back();
    test_reset_mid_shift();
    test_random(0, 1500, 15, 15);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
